n64_pi_bridge: RTL and testbench

N64_PI_BRIDGE -- requirements
Module: n64_pi_bridge

---
 rtl/sc64_pkg.sv | 20 ++
 rtl/n64_pi_sync.sv | 26 ++
 rtl/n64_pi_bridge.sv | 143 ++++++++++++++
 tb/tb_n64_pi_bridge.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sc64_pkg.sv
// Shared SC64 constants: firmware version and N64 PI address map, plus the PI
// address stepping helper used by the bridge.
package sc64_pkg;

  localparam logic [31:0] SC64_VERSION = 32'h5343_7632;

  localparam logic [31:0] PI_DOM1_ADDR1_BASE = 32'h0600_0000;
  localparam logic [31:0] PI_DOM1_ADDR1_END  = 32'h07FF_FFFF;
  localparam logic [31:0] PI_DOM1_ADDR2_BASE = 32'h1000_0000;
  localparam logic [31:0] PI_DOM1_ADDR2_END  = 32'h1FBF_FFFF;

  localparam int PI_AD_W   = 16;
  localparam int PI_ADDR_W = 32;

  // PI bursts advance one 16-bit half-word; wraps modulo 2^32.
  function automatic logic [PI_ADDR_W-1:0] pi_addr_inc(input logic [PI_ADDR_W-1:0] a);
    return a + 32'd2;
  endfunction

endpackage

// File: rtl/n64_pi_sync.sv
// N-stage flop chain bringing an asynchronous PI signal into the clk domain.
module n64_pi_sync #(
  parameter int             STAGES  = 2,
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [STAGES-1:0][W-1:0] pipe_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q <= {STAGES{RST_VAL}};
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[STAGES-1];

endmodule

// File: rtl/n64_pi_bridge.sv
// N64 PI slave bridge: latches the PI address from ALE phases, turns read/write
// strobes into single requests on the internal bus and steps the burst address.
module n64_pi_bridge
  import sc64_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 n64_pi_aleh,
  input  logic                 n64_pi_alel,
  input  logic                 n64_pi_read_n,
  input  logic                 n64_pi_write_n,
  input  logic [PI_AD_W-1:0]   n64_pi_ad_in,
  output logic [PI_AD_W-1:0]   n64_pi_ad_out,
  output logic                 n64_pi_ad_oe,
  output logic                 bus_request,
  output logic                 bus_write,
  output logic [PI_ADDR_W-1:0] bus_address,
  output logic [PI_AD_W-1:0]   bus_wdata,
  input  logic                 bus_ack,
  input  logic [PI_AD_W-1:0]   bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_READ_HOLD, S_WRITE} e_state;

  logic               aleh_s, alel_s, read_n_s, write_n_s;
  logic [PI_AD_W-1:0] ad_s;

  n64_pi_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b0)) u_sync_aleh (
    .clk(clk), .reset_n(reset_n), .d_i(n64_pi_aleh), .q_o(aleh_s));
  n64_pi_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b0)) u_sync_alel (
    .clk(clk), .reset_n(reset_n), .d_i(n64_pi_alel), .q_o(alel_s));
  n64_pi_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b1)) u_sync_read (
    .clk(clk), .reset_n(reset_n), .d_i(n64_pi_read_n), .q_o(read_n_s));
  n64_pi_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b1)) u_sync_write (
    .clk(clk), .reset_n(reset_n), .d_i(n64_pi_write_n), .q_o(write_n_s));
  // AD rides the same depth so it lines up with the strobe edges it qualifies.
  n64_pi_sync #(.STAGES(SYNC_STAGES), .W(PI_AD_W), .RST_VAL('0)) u_sync_ad (
    .clk(clk), .reset_n(reset_n), .d_i(n64_pi_ad_in), .q_o(ad_s));

  e_state               state_q, state_d;
  logic                 aleh_q, alel_q, read_n_q, write_n_q;
  logic                 req_q, req_d, wr_q, wr_d, inc;
  logic [PI_ADDR_W-1:0] addr_q, addr_d, addr_ale;
  logic [PI_AD_W-1:0]   wdata_q, wdata_d, ad_out_q, ad_out_d;

  wire aleh_fall  = aleh_q & ~aleh_s;
  wire alel_fall  = alel_q & ~alel_s & ~aleh_s;
  wire read_fall  = read_n_q & ~read_n_s;
  wire read_rise  = ~read_n_q & read_n_s;
  wire write_rise = ~write_n_q & write_n_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      aleh_q    <= 1'b0;
      alel_q    <= 1'b0;
      read_n_q  <= 1'b1;
      write_n_q <= 1'b1;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ad_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      aleh_q    <= aleh_s;
      alel_q    <= alel_s;
      read_n_q  <= read_n_s;
      write_n_q <= write_n_s;
      req_q     <= req_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ad_out_q  <= ad_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    ad_out_d = ad_out_q;
    inc      = 1'b0;
    addr_ale = addr_q;
    if (aleh_fall) addr_ale[31:16] = ad_s;
    if (alel_fall) addr_ale[15:0]  = {ad_s[15:1], 1'b0};

    case (state_q)
      S_IDLE: begin
        if (write_rise) begin
          wdata_d = ad_s;
          req_d   = 1'b1;
          wr_d    = 1'b1;
          state_d = S_WRITE;
        end else if (read_fall) begin
          req_d   = 1'b1;
          wr_d    = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (bus_ack) begin
          req_d = 1'b0;
          // Strobe already released: the N64 no longer wants this data.
          if (read_n_s) begin
            inc     = 1'b1;
            state_d = S_IDLE;
          end else begin
            ad_out_d = bus_rdata;
            state_d  = S_READ_HOLD;
          end
        end
      end
      S_READ_HOLD: begin
        if (read_rise) begin
          inc     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (bus_ack) begin
          req_d   = 1'b0;
          inc     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    addr_d = inc ? pi_addr_inc(addr_ale) : addr_ale;
  end

  assign bus_request   = req_q;
  assign bus_write     = wr_q;
  assign bus_address   = addr_q;
  assign bus_wdata     = wdata_q;
  assign n64_pi_ad_out = ad_out_q;
  assign n64_pi_ad_oe  = ~read_n_s & ~aleh_s & ~alel_s;

endmodule

// File: tb/tb_n64_pi_bridge.sv
// Randomized bench for n64_pi_bridge: PI-side stimulus, bus responder, and an
// address/data model derived from the PI transaction rules.
module tb_n64_pi_bridge;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        aleh = 1'b0, alel = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [15:0] ad_in = '0, ad_out, bus_wdata, bus_rdata = '0;
  logic        ad_oe, bus_request, bus_write, bus_ack = 1'b0;
  logic [31:0] bus_address;

  always #5 clk = ~clk;

  n64_pi_bridge #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .n64_pi_aleh(aleh), .n64_pi_alel(alel),
    .n64_pi_read_n(read_n), .n64_pi_write_n(write_n),
    .n64_pi_ad_in(ad_in), .n64_pi_ad_out(ad_out), .n64_pi_ad_oe(ad_oe),
    .bus_request(bus_request), .bus_write(bus_write), .bus_address(bus_address),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata));

  int n_chk = 0, n_fail = 0;

  // responder controls (main writes) and request log (responder writes)
  int          ack_dly = 3, late_req = 0;
  logic [15:0] rd_val = '0;
  int          nreq = 0, r_cnt = 0, late_done = 0;
  bit          r_busy = 1'b0;
  logic        lr_write = 1'b0;
  logic [31:0] lr_addr = '0;
  logic [15:0] lr_wdata = '0;

  // model state
  logic [31:0] m_addr = '0;
  logic [15:0] m_adout = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : responder
    forever begin
      @(posedge clk); #1;
      if (bus_ack) bus_ack = 1'b0;
      else if (late_req != late_done) begin
        late_done = late_req;
        bus_ack   = 1'b1;
        bus_rdata = 16'hDEAD;
      end else if (bus_request) begin
        if (!r_busy) begin
          r_busy = 1'b1; r_cnt = 0; nreq++;
          lr_write = bus_write; lr_addr = bus_address; lr_wdata = bus_wdata;
        end
        r_cnt++;
        if (r_cnt >= ack_dly) begin
          bus_ack = 1'b1; bus_rdata = rd_val; r_busy = 1'b0;
        end
      end else r_busy = 1'b0;
    end
  end

  task automatic wait_done(input int n);
    int t = 0;
    while (!(nreq == n && !bus_request && !bus_ack) && t < 300) begin
      cyc(1); t++;
    end
    if (t >= 300) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic do_ale(input logic [15:0] hi, input logic [15:0] lo);
    ad_in = hi; aleh = 1'b1; alel = 1'b1; cyc(3);
    aleh = 1'b0; cyc(3);
    ad_in = lo; cyc(3);
    alel = 1'b0; cyc(4);
    m_addr = {hi, lo & 16'hFFFE};
    chk("ale_addr", bus_address, m_addr);
  endtask

  task automatic do_read(input logic [15:0] rd, input bit abort);
    int n0 = nreq;
    rd_val = rd;
    read_n = 1'b0;
    if (abort) begin cyc(6); read_n = 1'b1; end
    wait_done(n0 + 1);
    chk("rd_req_addr", lr_addr, m_addr);
    chk("rd_req_wr", lr_write, 1'b0);
    if (!abort) begin
      chk("rd_oe_on", ad_oe, 1'b1);
      chk("rd_data", ad_out, rd);
      chk("rd_addr_hold", bus_address, m_addr);
      m_adout = rd;
      read_n = 1'b1;
    end
    cyc(5);
    m_addr = m_addr + 32'd2;
    chk("rd_addr_next", bus_address, m_addr);
    chk("rd_nreq", nreq, n0 + 1);
    chk("rd_oe_off", ad_oe, 1'b0);
    chk("rd_adout_keep", ad_out, m_adout);
  endtask

  task automatic do_write(input logic [15:0] d);
    int n0 = nreq;
    ad_in = d; write_n = 1'b0; cyc(3);
    write_n = 1'b1;
    wait_done(n0 + 1);
    chk("wr_req_wr", lr_write, 1'b1);
    chk("wr_req_addr", lr_addr, m_addr);
    chk("wr_req_data", lr_wdata, d);
    m_addr = m_addr + 32'd2;
    chk("wr_addr_next", bus_address, m_addr);
    cyc(3);
    chk("wr_nreq", nreq, n0 + 1);
  endtask

  initial begin : main
    int n0, t;
    cyc(3);
    chk("rst_req", bus_request, 1'b0);
    chk("rst_wr", bus_write, 1'b0);
    chk("rst_addr", bus_address, 32'h0);
    chk("rst_wdata", bus_wdata, 16'h0);
    chk("rst_adout", ad_out, 16'h0);
    chk("rst_oe", ad_oe, 1'b0);
    reset_n = 1'b1; cyc(3);

    ack_dly = 3;
    do_ale(16'h1000, 16'h0000);
    do_read(16'hBEEF, 1'b0);
    chk("basic_rd_addr", bus_address, 32'h1000_0002);

    do_ale(16'h1FFF, 16'hFFFE);
    do_write(16'h1234);
    chk("wr_cross_addr", bus_address, 32'h2000_0000);

    do_ale(16'hFFFF, 16'hFFFE);
    do_read(16'($urandom), 1'b0);
    chk("wrap_addr", bus_address, 32'h0);

    ack_dly = 20;
    do_read(16'h5555, 1'b1);
    n0 = nreq; cyc(10);
    chk("abort_no_2nd_req", nreq, n0);

    ack_dly = 2;
    do_ale(16'h1234, 16'h5670);
    repeat (4) do_read(16'($urandom), 1'b0);
    chk("burst4_addr", bus_address, 32'h1234_5678);

    // write strobe rising together with read strobe falling: write wins
    n0 = nreq; ad_in = 16'hA5A5; write_n = 1'b0; cyc(3);
    read_n = 1'b0; write_n = 1'b1;
    wait_done(n0 + 1);
    chk("collide_wr", lr_write, 1'b1);
    chk("collide_data", lr_wdata, 16'hA5A5);
    m_addr = m_addr + 32'd2;
    read_n = 1'b1; cyc(6);
    chk("collide_nreq", nreq, n0 + 1);
    chk("collide_addr", bus_address, m_addr);

    // reset in the middle of an outstanding read
    do_ale(16'h4321, 16'h8766);
    ack_dly = 1000; n0 = nreq; read_n = 1'b0; t = 0;
    while (!bus_request && t < 20) begin cyc(1); t++; end
    chk("mid_req_seen", bus_request, 1'b1);
    #2; reset_n = 1'b0; read_n = 1'b1; #1;
    chk("mid_rst_req", bus_request, 1'b0);
    chk("mid_rst_wr", bus_write, 1'b0);
    chk("mid_rst_addr", bus_address, 32'h0);
    chk("mid_rst_wdata", bus_wdata, 16'h0);
    chk("mid_rst_adout", ad_out, 16'h0);
    chk("mid_rst_oe", ad_oe, 1'b0);
    cyc(2); reset_n = 1'b1; ack_dly = 3; cyc(3);
    late_req++; cyc(5);
    chk("late_ack_req", bus_request, 1'b0);
    chk("late_ack_addr", bus_address, 32'h0);
    chk("late_ack_adout", ad_out, 16'h0);
    chk("late_ack_nreq", nreq, n0 + 1);
    m_addr = '0; m_adout = '0;
    do_write(16'h0F0F);

    for (int i = 0; i < 40; i++) begin
      ack_dly = $urandom_range(1, 8);
      case ($urandom_range(0, 3))
        0: do_ale(16'($urandom), 16'($urandom));
        1: do_read(16'($urandom), 1'b0);
        2: do_write(16'($urandom));
        default: begin ack_dly = $urandom_range(12, 20); do_read(16'($urandom), 1'b1); end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
